// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl
//   Scans a 4x4 active-low matrix keypad, debounces presses over whole scans
//   and turns each accepted key into operand-entry strobes and levels for the
//   downstream operand memory / BCD ALU.
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous reset, active low (released synchronously)
//   col_n     in   [3:0] keypad columns, active low, already synchronised
//   row_n     out  [3:0] keypad rows, exactly one driven low
//   is_num    out  one-cycle pulse, num_val holds a freshly accepted digit
//   is_op1    out  level, digits go to operand 1
//   is_op2    out  level, digits go to operand 2
//   num_val   out  [3:0] last accepted digit, held between pulses
//   op_val    out  [3:0] 4'b1101 add, 4'b1110 subtract
//
// Optional build macro KEYPAD_DEBUG_EN adds:
//   key_code    out [3:0] last accepted key code (reset 0)
//   key_strobe  out one pulse per accepted key, aligned with the entry action
module keypad_entry_ctrl #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20,
  parameter int MAX_DIGITS   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       is_num,
  output logic       is_op1,
  output logic       is_op2,
  output logic [3:0] num_val,
`ifdef KEYPAD_DEBUG_EN
  output logic [3:0] op_val,
  output logic [3:0] key_code,
  output logic       key_strobe
`else
  output logic [3:0] op_val
`endif
);

  localparam int DIVW = $clog2(SCAN_DIV + 1);
  localparam int DW   = $clog2(DEBOUNCE_CNT + 1);
  localparam int CW   = $clog2(MAX_DIGITS + 1);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCAN_DIV - 1);
  localparam logic [DW-1:0]   DEB_LAST = DW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0]   DIG_MAX  = CW'(MAX_DIGITS);

  typedef enum logic [1:0] {S_SCAN, S_DEB, S_HELD} scan_st_t;
  typedef enum logic [1:0] {E_OP1, E_OP2, E_DONE} entry_st_t;

  // Reset synchroniser: assertion is immediate, release waits two clocks.
  logic r_rst_meta, r_rst_sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  logic w_rst_n;
  assign w_rst_n = r_rst_sync;

  function automatic logic [3:0] f_keymap(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: f_keymap = 4'h1;  4'h1: f_keymap = 4'h2;
      4'h2: f_keymap = 4'h3;  4'h3: f_keymap = 4'hA;
      4'h4: f_keymap = 4'h4;  4'h5: f_keymap = 4'h5;
      4'h6: f_keymap = 4'h6;  4'h7: f_keymap = 4'hB;
      4'h8: f_keymap = 4'h7;  4'h9: f_keymap = 4'h8;
      4'hA: f_keymap = 4'h9;  4'hB: f_keymap = 4'hC;
      4'hC: f_keymap = 4'hE;  4'hD: f_keymap = 4'h0;
      4'hE: f_keymap = 4'hF;  default: f_keymap = 4'hD;
    endcase
  endfunction

  // ---------------------------------------------------------------- row scan
  logic [DIVW-1:0] r_div;
  logic [1:0]      r_row;
  logic [3:0]      r_row_n;

  // Row-sample decode: a row yields a key only when exactly one column is low.
  logic       w_samp, w_end_scan, w_row_key;
  logic [1:0] w_col;
  logic [3:0] w_row_code;

  assign w_samp     = (r_div == DIV_LAST);
  assign w_end_scan = w_samp && (r_row == 2'd3);

  always_comb begin
    w_row_key = 1'b1;
    w_col     = 2'd0;
    case (col_n)
      4'b1110: w_col = 2'd0;
      4'b1101: w_col = 2'd1;
      4'b1011: w_col = 2'd2;
      4'b0111: w_col = 2'd3;
      default: w_row_key = 1'b0;
    endcase
  end

  assign w_row_code = f_keymap(r_row, w_col);

  // Per-scan accumulation: number of rows with a key (saturating at 2) and
  // the code of the one seen. A scan counts as "one key" only if exactly
  // one row reported a key.
  logic [1:0] r_hits;
  logic [3:0] r_acc_code;
  logic [1:0] w_hits;
  logic [3:0] w_fcode;
  logic       w_fkey, w_any;

  assign w_hits  = (r_hits == 2'd0) ? {1'b0, w_row_key} :
                   (w_row_key ? 2'd2 : r_hits);
  assign w_fcode = w_row_key ? w_row_code : r_acc_code;
  assign w_fkey  = (w_hits == 2'd1);
  assign w_any   = (w_hits != 2'd0);

  // --------------------------------------------------------------- debounce
  scan_st_t    r_sst;
  logic [DW-1:0] r_deb;
  logic [3:0]  r_cand;
  logic        r_key_evt;
  logic [3:0]  r_evt_code;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_div      <= '0;
      r_row      <= 2'd0;
      r_row_n    <= 4'b1110;
      r_hits     <= 2'd0;
      r_acc_code <= 4'h0;
      r_sst      <= S_SCAN;
      r_deb      <= '0;
      r_cand     <= 4'h0;
      r_key_evt  <= 1'b0;
      r_evt_code <= 4'h0;
    end else begin
      r_key_evt <= 1'b0;
      if (w_samp) begin
        r_div   <= '0;
        r_row   <= r_row + 2'd1;
        r_row_n <= {r_row_n[2:0], r_row_n[3]};
      end else begin
        r_div <= r_div + DIVW'(1);
      end

      if (w_samp && !w_end_scan) begin
        r_hits     <= w_hits;
        r_acc_code <= w_fcode;
      end

      if (w_end_scan) begin
        r_hits     <= 2'd0;
        r_acc_code <= 4'h0;
        case (r_sst)
          S_SCAN: begin
            if (w_fkey) begin
              r_cand <= w_fcode;
              if (DEBOUNCE_CNT <= 1) begin
                r_sst      <= S_HELD;
                r_deb      <= '0;
                r_key_evt  <= 1'b1;
                r_evt_code <= w_fcode;
              end else begin
                r_sst <= S_DEB;
                r_deb <= DW'(1);
              end
            end
          end
          S_DEB: begin
            if (w_fkey && (w_fcode == r_cand)) begin
              if (r_deb == DEB_LAST) begin
                r_sst      <= S_HELD;
                r_deb      <= '0;
                r_key_evt  <= 1'b1;
                r_evt_code <= r_cand;
              end else begin
                r_deb <= r_deb + DW'(1);
              end
            end else begin
              r_sst <= S_SCAN;
              r_deb <= '0;
            end
          end
          S_HELD: begin
            // Any key activity, including a different key, keeps us held.
            if (w_any) begin
              r_deb <= '0;
            end else if (r_deb == DEB_LAST) begin
              r_sst <= S_SCAN;
              r_deb <= '0;
            end else begin
              r_deb <= r_deb + DW'(1);
            end
          end
          default: begin
            r_sst <= S_SCAN;
            r_deb <= '0;
          end
        endcase
      end
    end
  end

  // ------------------------------------------------------------ entry FSM
  entry_st_t   r_est;
  logic [CW-1:0] r_dcnt;
  logic        r_is_num, r_is_op1, r_is_op2;
  logic [3:0]  r_num_val, r_op_val;
  logic [3:0]  r_dbg_code;
  logic        r_dbg_strobe;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_est        <= E_OP1;
      r_dcnt       <= '0;
      r_is_num     <= 1'b0;
      r_is_op1     <= 1'b1;
      r_is_op2     <= 1'b0;
      r_num_val    <= 4'h0;
      r_op_val     <= 4'b1101;
      r_dbg_code   <= 4'h0;
      r_dbg_strobe <= 1'b0;
    end else begin
      r_is_num     <= 1'b0;
      r_dbg_strobe <= r_key_evt;
      if (r_key_evt) begin
        r_dbg_code <= r_evt_code;
        case (r_evt_code)
          4'hD, 4'hE: begin
            // Key code doubles as the op encoding (D=1101 add, E=1110 sub).
            if (r_est == E_OP1) begin
              r_op_val <= r_evt_code;
              r_est    <= E_OP2;
              r_is_op1 <= 1'b0;
              r_is_op2 <= 1'b1;
              r_dcnt   <= '0;
            end else if ((r_est == E_OP2) && (r_dcnt == '0)) begin
              r_op_val <= r_evt_code;
            end
          end
          4'hF: begin
            if (r_est == E_OP2) begin
              r_est    <= E_DONE;
              r_is_op1 <= 1'b0;
              r_is_op2 <= 1'b0;
            end
          end
          4'hC: begin
            r_est    <= E_OP1;
            r_is_op1 <= 1'b1;
            r_is_op2 <= 1'b0;
            r_dcnt   <= '0;
            r_op_val <= 4'b1101;
          end
          4'hA, 4'hB: ;
          default: begin
            if ((r_est != E_DONE) && (r_dcnt < DIG_MAX)) begin
              r_num_val <= r_evt_code;
              r_is_num  <= 1'b1;
              r_dcnt    <= r_dcnt + CW'(1);
            end
          end
        endcase
      end
    end
  end

  assign row_n   = r_row_n;
  assign is_num  = r_is_num;
  assign is_op1  = r_is_op1;
  assign is_op2  = r_is_op2;
  assign num_val = r_num_val;
  assign op_val  = r_op_val;

`ifdef KEYPAD_DEBUG_EN
  assign key_code   = r_dbg_code;
  assign key_strobe = r_dbg_strobe;
`else
  logic w_dbg_unused;
  assign w_dbg_unused = ^{r_dbg_code, r_dbg_strobe};
`endif

endmodule
